alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-side consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts an operation (alu_control, operand_a, operand_b) over a valid/ready handshake and computes it.
- Presents the result to the downstream stage through a registered, two-entry skid-buffered output.
- Sits between the decode/operand-fetch logic and the memory/writeback stage; a downstream stall never loses a result.

Parameters:
- XLEN, 32, operand and result width in bits.
- CNT_W, 16, width of the completed-operation and illegal-operation counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_control  input  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR; any other code is illegal.
- operand_a  input  XLEN  first operand.
- operand_b  input  XLEN  second operand.
- out_valid  output  1  result, zero and illegal_op are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  XLEN  operation result.
- zero  output  1  result equals 0 for a legal operation.
- illegal_op  output  1  the operation carried an illegal code.
- ops_done  output  CNT_W  count of results handed downstream (out_valid & out_ready).
- illegal_cnt  output  CNT_W  count of accepted illegal operations, saturating.

Behaviour:
- Reset (async, rst=1):
  - Both buffer entries are invalidated: out_valid=0, result=0, zero=0, illegal_op=0.
  - ops_done=0, illegal_cnt=0, in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation discards all buffered results; nothing is replayed.
- Accept: fire_in = in_valid & in_ready. Handoff: fire_out = out_valid & out_ready.
- Arithmetic:
  - ADD is a + b mod 2^XLEN; SUB is a - b mod 2^XLEN. No overflow or carry flag; wrap-around is silent.
  - AND and OR are bitwise.
  - An illegal code gives result=0, zero=0, illegal_op=1.
  - For a legal code, zero = (result==0) and illegal_op=0.
- Latency: an operation accepted in cycle N appears on out_valid/result in cycle N+1 if the output entry is empty or draining.
- Buffer states (two registered entries, main and skid):
  - EMPTY: main and skid invalid. in_ready=1.
    - fire_in -> ONE.
  - ONE: main valid, skid invalid. in_ready=1.
    - fire_in & fire_out -> main takes the new result, stay ONE.
    - fire_in & !fire_out -> skid takes the new result, go FULL.
    - !fire_in & fire_out -> EMPTY.
  - FULL: main and skid valid. in_ready=0.
    - fire_out -> skid moves to main, go ONE.
    - No input is accepted in FULL.
- in_ready is a registered signal (1 in EMPTY and ONE, 0 in FULL) and never depends combinationally on out_ready.
- Output entries are stable while out_valid=1 and out_ready=0.
- Results leave in strict acceptance order; none is dropped or duplicated.
- Counters:
  - ops_done increments on each fire_out and wraps at 2^CNT_W.
  - illegal_cnt increments on fire_in with an illegal code and saturates at all-ones.
- in_valid with in_ready=0 has no effect. Inputs may change freely when not firing.

Test Plan:
- Reset, then out_ready=1; ADD a=5, b=7 -> next cycle out_valid=1, result=12, zero=0, illegal_op=0; ops_done=1 after handoff.
- SUB a=3, b=3 -> result=0, zero=1. SUB a=0, b=1 -> result=0xFFFFFFFF (wrap), zero=0. ADD 0xFFFFFFFF+1 -> result=0, zero=1.
- AND 0xF0F0_00FF & 0x0FF0_0F0F -> 0x00F0_000F. OR of the same operands -> 0xFFF0_0FFF. Code 1111 -> result=0, illegal_op=1, illegal_cnt=1.
- Hold out_ready=0 and issue three ops back-to-back:
  - First two accepted; in_ready=0 from the cycle after the second accept; third held.
  - Release out_ready: results emerge in order, then the third is accepted.
- Continuous in_valid=1 and out_ready=1 for 100 random ops -> one result per cycle, in order, matching a reference model; ops_done=100.
- Assert rst with FULL buffers -> out_valid=0, counters=0 immediately; after deassert, one ADD completes normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: executes ADD/SUB/AND/OR and hands results downstream through a two-entry skid buffer
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             illegal_op,
    output logic [CNT_W-1:0] ops_done,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
        logic            ill;
    } entry_t;

    buf_state_t       state_q, state_d;
    entry_t           main_q, main_d, skid_q, skid_d, new_e;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d, illegal_cnt_q, illegal_cnt_d;
    logic             fire_in, fire_out;

    assign fire_in     = in_valid & in_ready_q;
    assign fire_out    = out_valid & out_ready;
    assign in_ready    = in_ready_q;
    assign out_valid   = state_q != EMPTY;
    assign result      = main_q.res;
    assign zero        = main_q.zero;
    assign illegal_op  = main_q.ill;
    assign ops_done    = ops_done_q;
    assign illegal_cnt = illegal_cnt_q;

    // Decode the operation; illegal codes yield a zero result with zero flag forced low
    always_comb begin
        new_e.res = '0;
        new_e.ill = 1'b0;
        case (alu_control)
            4'b0010: new_e.res = operand_a + operand_b;
            4'b0110: new_e.res = operand_a - operand_b;
            4'b0000: new_e.res = operand_a & operand_b;
            4'b0001: new_e.res = operand_a | operand_b;
            default: new_e.ill = 1'b1;
        endcase
        new_e.zero = !new_e.ill && (new_e.res == '0);
    end

    // Buffer occupancy transitions, entry loading and counter updates
    always_comb begin
        state_d       = state_q;
        main_d        = main_q;
        skid_d        = skid_q;
        case (state_q)
            EMPTY: if (fire_in) begin
                main_d  = new_e;
                state_d = ONE;
            end
            ONE: if (fire_in && fire_out) begin
                main_d  = new_e;
            end else if (fire_in) begin
                skid_d  = new_e;
                state_d = FULL;
            end else if (fire_out) begin
                state_d = EMPTY;
            end
            FULL: if (fire_out) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d    = state_d != FULL;
        ops_done_d    = ops_done_q + CNT_W'(fire_out);
        illegal_cnt_d = (fire_in && new_e.ill && !(&illegal_cnt_q)) ? illegal_cnt_q + 1'b1 : illegal_cnt_q;
    end

    // State register with asynchronous reset discarding all buffered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            in_ready_q    <= 1'b1;
            ops_done_q    <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            in_ready_q    <= in_ready_d;
            ops_done_q    <= ops_done_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and model-checked vectors for alu_exec_stage
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;
    logic [15:0] ops_done;
    logic [15:0] illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;

    alu_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .illegal_op(illegal_op), .ops_done(ops_done), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_control = c;
        operand_a = a;
        operand_b = b;
    endtask

    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z, input logic il);
        drive(c, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, r);
        check({tag, "_zero"}, 32'(zero), 32'(z));
        check({tag, "_illegal"}, 32'(illegal_op), 32'(il));
        @(posedge clk); #1;
        exp_done++;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check({tag, "_ops_done"}, 32'(ops_done), 32'(exp_done));
    endtask

    initial begin
        logic [3:0]  codes [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
        logic [3:0]  rc;
        logic [31:0] ra, rb, rr;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        alu_control = 4'b0;
        operand_a = '0;
        operand_b = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        do_op("add5_7", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        do_op("sub3_3", 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        do_op("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        do_op("and", 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);
        do_op("or", 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0);
        do_op("illegal", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
        check("illegal_cnt_1", 32'(illegal_cnt), 32'd1);

        out_ready = 1'b0;
        drive(4'b0010, 32'd100, 32'd1);
        @(posedge clk); #1;
        check("bp_ready_one", 32'(in_ready), 32'd1);
        drive(4'b0110, 32'd50, 32'd8);
        @(posedge clk); #1;
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head1", result, 32'd101);
        drive(4'b0001, 32'h0000_0F00, 32'h0000_00F0);
        @(posedge clk); #1;
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_stable", result, 32'd101);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_head2", result, 32'd42);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_head3", result, 32'h0000_0FF0);
        check("bp_valid3", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        exp_done += 3;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_ops_done", 32'(ops_done), 32'(exp_done));

        for (int i = 0; i < 100; i++) begin
            rc = codes[$urandom_range(0, 3)];
            ra = $urandom;
            rb = (i % 7 == 0) ? ra : $urandom;
            rr = model(rc, ra, rb);
            drive(rc, ra, rb);
            @(posedge clk); #1;
            check($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("rnd%0d_result", i), result, rr);
            check($sformatf("rnd%0d_zero", i), 32'(zero), 32'(rr == 32'd0));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_done += 100;
        check("rnd_drained", 32'(out_valid), 32'd0);
        check("rnd_ops_done", 32'(ops_done), 32'(exp_done));
        check("rnd_illegal_cnt", 32'(illegal_cnt), 32'd1);

        out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd1);
        @(posedge clk); #1;
        drive(4'b0010, 32'd2, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_before_rst", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_ops_done", 32'(ops_done), 32'd0);
        check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("arst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        exp_done = 0;
        @(posedge clk); #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_no_replay", 32'(out_valid), 32'd0);
        do_op("post_rst_add", 4'b0010, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
